// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch front end.
// Entry layout, fetch FSM states and the ISA opcode field.
package cpu_pkg;

  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] HALT_WORD = 32'h0000_0000;

  // opcode lives in instr[31:29]
  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_SW  = 3'b001;
  localparam logic [2:0] OP_BEQ = 3'b010;
  localparam logic [2:0] OP_BLT = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_AND = 3'b110;
  localparam logic [2:0] OP_OR  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO between fetch and decode.
// Flush empties it in one edge; a push when full is accepted only with a pop.
module fetch_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // storage is cleared on reset so the head reads zero afterwards
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, fetch FSM and push/redirect arbitration.
// Entries {pc, instr} are queued to decode through fetch_fifo.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC     = 16'h0000,
  parameter int                FIFO_DEPTH   = 2,
  parameter bit                HALT_ON_ZERO = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  inst_address,
  input  logic [INSTR_W-1:0] inst_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               halted
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              push, pop, flush;
  logic              full, empty;
  fetch_entry_t      head, entry;

  assign inst_address = pc_q;
  assign dec_valid    = !empty;
  assign pop          = dec_valid && dec_ready;
  assign dec_pc       = head.pc;
  assign dec_instr    = head.instr;
  assign halted       = (state_q == HALT);
  assign entry        = '{pc: pc_q, instr: inst_data};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_valid) begin
      flush   = 1'b1;
      pc_d    = redirect_pc;
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE: if (start) state_d = RUN;
        RUN: begin
          if (!full || pop) begin
            push = 1'b1;
            // the end marker is queued but nothing is fetched after it
            if (HALT_ON_ZERO && inst_data == HALT_WORD) state_d = HALT;
            else pc_d = pc_q + 1'b1;
          end
        end
        HALT: ;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  (entry),
    .full_o  (full),
    .empty_o (empty),
    .head_o  (head)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a 256-word memory model.
// Demo program in words 0..10, word 10 is the end marker.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n, start, dec_ready, redirect_valid;
  logic [15:0] redirect_pc, inst_address, dec_pc;
  logic [31:0] inst_data, dec_instr;
  logic        dec_valid, halted;
  logic [31:0] ram [256];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign inst_data = ram[inst_address[7:0]];

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .inst_address   (inst_address),
    .inst_data      (inst_data),
    .dec_valid      (dec_valid),
    .dec_ready      (dec_ready),
    .dec_instr      (dec_instr),
    .dec_pc         (dec_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = {16'hA5A5, 16'(i)};
    ram[0]  = 32'h0040_0000;
    ram[1]  = 32'h0060_0001;
    ram[2]  = 32'h8000_4000;
    ram[3]  = 32'hA000_0003;
    ram[4]  = 32'h6000_000A;
    ram[5]  = 32'h4120_000B;
    ram[6]  = 32'hC000_0000;
    ram[7]  = 32'hE000_0000;
    ram[8]  = 32'h2000_0002;
    ram[9]  = 32'h4000_0000;
    ram[10] = 32'h0000_0000;

    rst_n = 1'b0;
    start = 1'b0;
    dec_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_addr", 32'(inst_address), 32'h0);
    chk("rst_instr", dec_instr, 32'h0);
    chk("rst_pc", 32'(dec_pc), 32'h0);

    // 1: streaming with decode always ready
    dec_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t1_valid0", 32'(dec_valid), 32'd0);
    chk("t1_addr0", 32'(inst_address), 32'h0);
    tick();
    chk("t1_valid", 32'(dec_valid), 32'd1);
    chk("t1_pc0", 32'(dec_pc), 32'h0);
    chk("t1_instr0", dec_instr, 32'h0040_0000);
    tick();
    chk("t1_pc1", 32'(dec_pc), 32'h1);
    chk("t1_instr1", dec_instr, 32'h0060_0001);
    tick();
    chk("t1_pc2", 32'(dec_pc), 32'h2);
    chk("t1_instr2", dec_instr, 32'h8000_4000);
    tick();
    chk("t1_pc3", 32'(dec_pc), 32'h3);
    do_reset();

    // 2: decode stalled 5 clks, queue fills and pc holds
    dec_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("t2_valid", 32'(dec_valid), 32'd1);
    chk("t2_head", 32'(dec_pc), 32'h0);
    chk("t2_hold", 32'(inst_address), 32'h2);
    dec_ready = 1'b1;
    tick();
    chk("t2_pc1", 32'(dec_pc), 32'h1);
    tick();
    chk("t2_pc2", 32'(dec_pc), 32'h2);
    chk("t2_instr2", dec_instr, 32'h8000_4000);
    do_reset();

    // 3: redirect to 5 with full queue and simultaneous pop
    dec_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("t3_full_addr", 32'(inst_address), 32'h2);
    dec_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'h0005;
    tick();
    redirect_valid = 1'b0;
    chk("t3_flushed", 32'(dec_valid), 32'd0);
    chk("t3_addr", 32'(inst_address), 32'h5);
    tick();
    chk("t3_valid", 32'(dec_valid), 32'd1);
    chk("t3_pc", 32'(dec_pc), 32'h5);
    chk("t3_instr", dec_instr, 32'h4120_000B);

    // 4: run into the end marker at pc 10
    repeat (5) tick();
    chk("t4_pc10", 32'(dec_pc), 32'hA);
    chk("t4_word0", dec_instr, 32'h0);
    chk("t4_halted", 32'(halted), 32'd1);
    chk("t4_addr", 32'(inst_address), 32'hA);
    tick();
    chk("t4_drained", 32'(dec_valid), 32'd0);
    chk("t4_addr_hold", 32'(inst_address), 32'hA);
    chk("t4_still_halt", 32'(halted), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0000;
    tick();
    redirect_valid = 1'b0;
    chk("t4_unhalt", 32'(halted), 32'd0);
    chk("t4_restart", 32'(inst_address), 32'h0);
    tick();
    chk("t4_valid", 32'(dec_valid), 32'd1);
    chk("t4_pc0", 32'(dec_pc), 32'h0);

    // 5: reset with two queued entries
    dec_ready = 1'b0;
    tick();
    chk("t5_pre_valid", 32'(dec_valid), 32'd1);
    chk("t5_pre_addr", 32'(inst_address), 32'h2);
    do_reset();
    chk("t5_valid", 32'(dec_valid), 32'd0);
    chk("t5_halted", 32'(halted), 32'd0);
    chk("t5_addr", 32'(inst_address), 32'h0);
    repeat (3) tick();
    chk("t5_idle_valid", 32'(dec_valid), 32'd0);
    chk("t5_idle_addr", 32'(inst_address), 32'h0);

    // 6: wrap-around from FFFF
    dec_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    chk("t6_addr", 32'(inst_address), 32'hFFFF);
    tick();
    chk("t6_pcffff", 32'(dec_pc), 32'hFFFF);
    chk("t6_instr", dec_instr, 32'hA5A5_00FF);
    tick();
    chk("t6_pc0", 32'(dec_pc), 32'h0);
    chk("t6_instr0", dec_instr, 32'h0040_0000);
    chk("t6_addr1", 32'(inst_address), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
